// File: rtl/sched_ws_if.sv
// Control/status bundle between the phase sequencer and the CPU top.
// The bench (or CPU) drives through master; the sequencer uses slave.
interface sched_ws_if #(
   parameter int WS_WIDTH  = 4,
   parameter int CNT_WIDTH = 32
);
   logic                 run_en;
   logic                 step;
   logic [WS_WIDTH-1:0]  mem_ws;
   logic                 mem_ready;
   logic                 ldst;
   logic                 phf;
   logic                 phe;
   logic                 phm;
   logic                 phw;
   logic                 stall;
   logic                 halted;
   logic [2:0]           clk_stat;
   logic [CNT_WIDTH-1:0] inst_cnt;

   modport master (
      output run_en, step, mem_ws, mem_ready, ldst,
      input  phf, phe, phm, phw, stall, halted, clk_stat, inst_cnt
   );

   modport slave (
      input  run_en, step, mem_ws, mem_ready, ldst,
      output phf, phe, phm, phw, stall, halted, clk_stat, inst_cnt
   );
endinterface

// File: rtl/sched_ws.sv
// Four-phase CPU sequencer (F,E,M,W) with memory wait states, ready handshake,
// run/halt/single-step control and a retired-instruction counter.
module sched_ws #(
   parameter int WS_WIDTH  = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   sched_ws_if.slave  bus
);

   typedef enum logic [2:0] {
      S_HALT = 3'b000,
      S_F    = 3'b001,
      S_E    = 3'b010,
      S_M    = 3'b011,
      S_W    = 3'b100
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [WS_WIDTH-1:0]  wcnt;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 step_q;
   logic                 step_pend;
   logic                 step_rise;
   logic                 wait_phase;
   logic                 mem_done;
   logic                 load_wcnt;

   assign step_rise  = bus.step & ~step_q;
   // Memory-using phases: every fetch, and a memory phase of a load/store.
   assign wait_phase = (state == S_F) || ((state == S_M) && bus.ldst);
   assign mem_done   = (wcnt == '0) && bus.mem_ready;
   assign bus.stall  = wait_phase && !mem_done;
   assign load_wcnt  = ((state_nxt == S_F) && (state != S_F)) ||
                       ((state_nxt == S_M) && (state != S_M) && bus.ldst);
   assign bus.inst_cnt = cnt;

   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      unique case (state)
         S_HALT:  if (bus.run_en || step_rise) state_nxt = S_F;
         S_F:     if (mem_done) state_nxt = S_E;
         S_E:     state_nxt = S_M;
         S_M:     if (!bus.ldst || mem_done) state_nxt = S_W;
         S_W:     state_nxt = bus.run_en ? S_F : S_HALT;
         default: state_nxt = S_HALT;
      endcase
   end

   // Phase strobes are flops loaded from the next state, so they are glitch-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
         state        <= S_HALT;
         bus.phf      <= 1'b0;
         bus.phe      <= 1'b0;
         bus.phm      <= 1'b0;
         bus.phw      <= 1'b0;
         bus.halted   <= 1'b1;
         bus.clk_stat <= 3'b000;
      end else begin
         state        <= state_nxt;
         bus.phf      <= (state_nxt == S_F);
         bus.phe      <= (state_nxt == S_E);
         bus.phm      <= (state_nxt == S_M);
         bus.phw      <= (state_nxt == S_W);
         bus.halted   <= (state_nxt == S_HALT);
         bus.clk_stat <= state_nxt;
      end
   end

   // mem_ws is captured only on phase entry; later changes wait for the next entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt <= '0;
      end else if (load_wcnt) begin
         wcnt <= bus.mem_ws;
      end else if (wait_phase && (wcnt != '0)) begin
         wcnt <= wcnt - WS_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_q    <= 1'b0;
         step_pend <= 1'b0;
      end else begin
         step_q <= bus.step;
         if ((state == S_HALT) && step_rise) begin
            step_pend <= !bus.run_en;
         end else if ((state == S_W) && !bus.run_en && step_pend) begin
            step_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (state == S_W) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

   a_phase_onehot: assert property (@(posedge clk) disable iff (!reset)
      $onehot0({bus.phf, bus.phe, bus.phm, bus.phw}));

   a_halted_state: assert property (@(posedge clk) disable iff (!reset)
      bus.halted == (state == S_HALT));

   a_step_ends_halt: assert property (@(posedge clk) disable iff (!reset)
      ((state == S_W) && step_pend && !bus.run_en) |=> (state == S_HALT));

endmodule

// File: doc/sched_ws.md
Name: sched_ws

Overview:
Phase sequencer for the four-phase CPU datapath. It drives the one-hot phase strobes fetch (phf), execute (phe), memory (phm) and writeback (phw). It extends the basic fixed-rate scheduler with:
- programmable memory wait states and a ready handshake for slow memory;
- run/halt/single-step control;
- a retired-instruction counter for test and debug.

It sits between the clock/reset source and the CPU top, in place of the fixed-rate scheduler.

Parameters:
WS_WIDTH, 4, width of the wait-state count input and the internal wait counter.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, all state changes on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
run_en  input  1  1 = free-running execution; 0 = halt after the current instruction.
step  input  1  single-step request; rising edge detected internally.
mem_ws  input  WS_WIDTH  wait states added to the fetch phase and to memory-using memory phases.
mem_ready  input  1  memory completion; sampled only after the wait count has expired.
ldst  input  1  current instruction is a load or store (decoded from IC by the CPU).
phf  output  1  fetch phase strobe.
phe  output  1  execute phase strobe.
phm  output  1  memory phase strobe.
phw  output  1  writeback phase strobe.
stall  output  1  in F or M and not completing this cycle.
halted  output  1  sequencer is in HALT.
clk_stat  output  3  state code: 000 HALT, 001 F, 010 E, 011 M, 100 W.
inst_cnt  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (reset=0, async): state=HALT. phf/phe/phm/phw=0, stall=0, halted=1, clk_stat=000, inst_cnt=0, wait counter=0, step edge detector cleared.
- Phase outputs decode the state register directly (registered, no glitches). At most one is high. All are low in HALT.
- HALT -> F when run_en=1, or when a step rising edge is seen. The step request is latched as a one-shot step_pend. Otherwise stay in HALT.
- Wait counter wcnt is loaded with mem_ws on every transition into F. It is also loaded on transition into M when ldst=1. mem_ws changes after entry are ignored until the next entry.
- F: if wcnt!=0, decrement and stay (stall=1). If wcnt==0 and mem_ready=1, go to E (stall=0). If wcnt==0 and mem_ready=0, stay (stall=1).
- E: always exactly one cycle, then -> M.
- M with ldst=1: same wait/ready rule as F, then -> W.
- M with ldst=0: exactly one cycle, mem_ready ignored, stall=0, then -> W.
- W: always exactly one cycle. On the exit edge inst_cnt increments, wrapping from all-ones to 0. Next state:
  - run_en=1 -> F;
  - else step_pend=1 -> HALT, and step_pend is cleared;
  - else -> HALT.
- Single step therefore executes exactly one full F,E,M,W sequence. A steady-high step never triggers a second instruction; a new rising edge is required.
- Step edges seen while not in HALT are ignored, with no queuing.
- run_en sampled 0 in F, E or M does not abort. The instruction completes through W, then the sequencer halts.
- run_en rising while in HALT: F on the next edge.
- A step edge and run_en=1 on the same cycle in HALT: F, free-running. step_pend is cleared.
- Minimum instruction time is 4 cycles. Time with ldst=1 is 4 + 2*mem_ws + ready-stall cycles. Time with ldst=0 is 4 + mem_ws + fetch ready-stall cycles.
- Reset asserted in any state, including mid-wait, immediately forces the reset values. No partial instruction is counted.
- clk_stat follows state. stall is combinational from state, wcnt and mem_ready, and is valid only while in F/M.

Test Plan:
1. reset released, run_en=1, mem_ws=0, mem_ready=1, ldst=0 -> phf,phe,phm,phw each high 1 cycle in rotation. First phf on the first edge after release. inst_cnt=3 after 12 cycles.
2. mem_ws=2, ldst=1, mem_ready=1 -> phf high 3 cycles, phe 1, phm 3, phw 1. stall high for 2 cycles of each F and M. inst_cnt increments every 8 cycles.
3. mem_ws=0, mem_ready held 0 for 5 cycles after F entry -> phf high 6 cycles with stall=1 for the first 5. E entered on the cycle after mem_ready=1.
4. run_en=0 after reset, step held high 10 cycles -> exactly one F,E,M,W sequence, then halted=1, clk_stat=000, inst_cnt=1. A second step pulse gives inst_cnt=2.
5. run_en dropped to 0 during E -> M and W complete, then HALT. inst_cnt increments once, halted=1 on the cycle after phw.
6. reset driven low mid-M with mem_ws=3, ldst=1 -> all phase outputs 0 and inst_cnt=0 without waiting for a clock edge. After release with run_en=1, the next phase is F. With CNT_WIDTH=4, 16 instructions wrap inst_cnt to 0.
